// File: rtl/uart_rx_os16.sv
// uart_rx_os16 - 8-N-1 UART receiver with 16x oversampling.
//
// Bit timing is paced by os_tick, a one-clk pulse at 16x the baud rate. It is
// normally the carry output of the cascaded '163-style counter chain. Every
// bit is sampled at oversample index MID_SAMPLE of the start bit, and then
// every 16 ticks after that. Received words land in a holding register with a
// valid/ready handshake.
//
// Optional feature: define UART_RX_PARITY_EN to receive one even-parity bit
// between the data and stop bits. This also adds the parity_err output.
//
// Ports:
//   clk        system clock, rising edge
//   clr        synchronous reset, active-high
//   os_tick    16x-baud enable pulse
//   rxd        asynchronous serial input, idle high
//   rx_data    received word, stable while rx_valid=1
//   rx_valid   holding register full
//   rx_ready   consumer accepts rx_data when rx_valid & rx_ready
//   frame_err  one-clk pulse: stop bit sampled low
//   overrun    one-clk pulse: frame completed while holding register full
//   parity_err one-clk pulse at commit on even-parity mismatch (UART_RX_PARITY_EN only)
//   busy       receiver not idle
module uart_rx_os16 #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned MID_SAMPLE = 7
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 os_tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [3:0] MID      = 4'(MID_SAMPLE);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  state_t               state_q;
  logic [3:0]           os_cnt_q;
  logic [3:0]           bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 rxd_meta_q;
  logic                 rxd_s_q;
  logic                 commit_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
  logic                 overrun_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit_q;
  logic                 perr_pend_q;
  logic                 parity_err_q;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= S_IDLE;
      os_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rxd_meta_q  <= 1'b1;
      rxd_s_q     <= 1'b1;
      commit_q    <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      perr_pend_q  <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rxd_meta_q  <= rxd;
      rxd_s_q     <= rxd_meta_q;
      commit_q    <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif

      if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end

      // A commit overrides the acceptance clear above. A word accepted on
      // the same edge is replaced without a bubble.
      if (commit_q) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_q  <= shift_q;
          rx_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
`ifdef UART_RX_PARITY_EN
        // Flagged on the commit edge even when the word is dropped by overrun.
        parity_err_q <= perr_pend_q;
`endif
      end

      if (os_tick) begin
        os_cnt_q <= os_cnt_q + 4'd1;
        case (state_q)
          S_IDLE: begin
            if (!rxd_s_q) begin
              state_q  <= S_START;
              os_cnt_q <= '0;
            end
          end
          S_START: begin
            if (os_cnt_q == MID) begin
              os_cnt_q <= '0;
              if (!rxd_s_q) begin
                state_q   <= S_DATA;
                bit_cnt_q <= '0;
              end else begin
                state_q <= S_IDLE;
              end
            end
          end
          S_DATA: begin
            // The counter wraps 15->0 here, so the next sample is 16 ticks later.
            if (os_cnt_q == 4'hF) begin
              shift_q   <= {rxd_s_q, shift_q[DATA_BITS-1:1]};
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                state_q <= S_PARITY;
`else
                state_q <= S_STOP;
`endif
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          S_PARITY: begin
            if (os_cnt_q == 4'hF) begin
              par_bit_q <= rxd_s_q;
              state_q   <= S_STOP;
            end
          end
`endif
          S_STOP: begin
            // Back to IDLE at mid-stop, so a start bit that follows
            // immediately is still caught.
            if (os_cnt_q == 4'hF) begin
              state_q <= S_IDLE;
              if (rxd_s_q) begin
                commit_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                perr_pend_q <= ^{shift_q, par_bit_q};
`endif
              end else begin
                frame_err_q <= 1'b1;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_os16.sv
`timescale 1ns/1ps
module tb_uart_rx_os16;

  logic       clk = 1'b0;
  logic       clr;
  logic       os_tick;
  logic       rxd;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  always #5 clk = ~clk;

  uart_rx_os16 #(
    .DATA_BITS (8),
    .MID_SAMPLE(7)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .os_tick  (os_tick),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy     (busy)
  );

  typedef enum int {EV_DATA, EV_FERR, EV_OVR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
    logic       perr;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned cyc   = 0;
  int unsigned div   = 4;
  bit          tick_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input ev_kind_t k, input logic [7:0] d, input logic p);
    exp_t e;
    e.kind = k;
    e.data = d;
    e.perr = p;
    sb_q.push_back(e);
  endtask

  task automatic pop_exp(input string name, input ev_kind_t k, output exp_t e, output bit ok);
    ok = 1'b0;
    e.kind = EV_DATA;
    e.data = '0;
    e.perr = 1'b0;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: got unexpected event %0d, expected no event", name, k);
    end else begin
      e = sb_q.pop_front();
      if (e.kind != k) begin
        n_err++;
        $display("FAIL %s: got event %0d, expected event %0d", name, k, e.kind);
      end else begin
        ok = 1'b1;
      end
    end
  endtask

  // Inputs change 1ns after the rising edge; the monitor samples on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    os_tick = tick_en && ((cyc % div) == 0);
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (16 * div) step();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ bad_par);
`else
    if (bad_par) $display("note: parity not built in, bad_par ignored");
`endif
    send_bit(stop_bit);
    rxd = 1'b1;
  endtask

  task automatic latency_watch();
    int unsigned n;
    n = 0;
    while (!busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("busy_rise", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("busy_fall_at_stop", 32'(busy), 32'd0);
    check("valid_low_at_stop_edge", 32'(rx_valid), 32'd0);
    @(negedge clk);
    check("valid_one_clk_after_stop", 32'(rx_valid), 32'd1);
  endtask

  // Monitor: every output event pops one expected record off the scoreboard.
  initial begin
    exp_t e;
    bit   ok;
    forever begin
      @(negedge clk);
      if (!clr) begin
        if (frame_err) begin
          pop_exp("frame_err_event", EV_FERR, e, ok);
          if (ok) check("frame_err_rx_data_kept", 32'(rx_data), 32'(e.data));
        end
        if (overrun) begin
          pop_exp("overrun_event", EV_OVR, e, ok);
          if (ok) check("overrun_rx_data_kept", 32'(rx_data), 32'(e.data));
        end
        if (rx_valid && rx_ready) begin
          pop_exp("data_event", EV_DATA, e, ok);
          if (ok) begin
            check("rx_data", 32'(rx_data), 32'(e.data));
`ifdef UART_RX_PARITY_EN
            check("parity_err", 32'(parity_err), 32'(e.perr));
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        else if (parity_err) begin
          check("parity_err_outside_accept", 32'(parity_err), 32'd0);
        end
`endif
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    clr      = 1'b1;
    rxd      = 1'b1;
    rx_ready = 1'b1;
    os_tick  = 1'b0;
    repeat (4) step();
    @(negedge clk);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    clr     = 1'b0;
    tick_en = 1'b1;
    div     = 4;
    repeat (40) step();

    // Good byte with latency check.
    push_exp(EV_DATA, 8'hA5, 1'b0);
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      latency_watch();
    join
    repeat (64) step();

    // Glitch: 3 ticks low, then high.
    rxd = 1'b0;
    repeat (3 * div) step();
    check("glitch_busy_high", 32'(busy), 32'd1);
    rxd = 1'b1;
    repeat (16 * div) step();
    check("glitch_busy_dropped", 32'(busy), 32'd0);
    check("glitch_no_valid", 32'(rx_valid), 32'd0);

    // Framing error; rx_data keeps 0xA5.
    push_exp(EV_FERR, 8'hA5, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (32 * div) step();
    check("ferr_no_valid", 32'(rx_valid), 32'd0);
    check("ferr_rx_data_unchanged", 32'(rx_data), 32'hA5);

    // Overrun: two frames back-to-back with the consumer stalled.
    rx_ready = 1'b0;
    push_exp(EV_OVR, 8'h11, 1'b0);
    send_frame(8'h11, 1'b1, 1'b0);
    check("ovr_first_valid", 32'(rx_valid), 32'd1);
    check("ovr_first_data", 32'(rx_data), 32'h11);
    send_frame(8'h22, 1'b1, 1'b0);
    repeat (16 * div) step();
    check("ovr_still_valid", 32'(rx_valid), 32'd1);
    push_exp(EV_DATA, 8'h11, 1'b0);
    rx_ready = 1'b1;
    step();
    check("ovr_valid_falls_next_clk", 32'(rx_valid), 32'd0);
    repeat (16) step();

    // Reset during the 4th data bit of 0xFF.
    send_bit(1'b0);
    repeat (3) send_bit(1'b1);
    rxd = 1'b1;
    repeat (8 * div) step();
    check("midframe_busy_before_clr", 32'(busy), 32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_rx_data", 32'(rx_data), 32'd0);
    check("clr_rx_valid", 32'(rx_valid), 32'd0);
    check("clr_frame_err", 32'(frame_err), 32'd0);
    check("clr_overrun", 32'(overrun), 32'd0);
    check("clr_busy", 32'(busy), 32'd0);
    repeat (6 * 16 * div) step();
    push_exp(EV_DATA, 8'h5A, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0);
    repeat (32 * div) step();

    // os_tick held high: one oversample per clk.
    div = 1;
    push_exp(EV_DATA, 8'hC3, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    repeat (64) step();
    div = 4;

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight, so a parity bit of 0 is a mismatch.
    push_exp(EV_DATA, 8'h07, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (32 * div) step();
    push_exp(EV_DATA, 8'h07, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (32 * div) step();
`endif

    repeat (20) step();
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
